// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and packet constants for the UART transmit scheduler.
// Heartbeat packets carry type 2'b11 in the top two bits and an all-zero payload.
package uart_tx_scheduler_pkg;

   localparam int PKT_W = 16;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LAUNCH     = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      GAP        = 3'd4
   } tx_sched_state_t;

   localparam logic [1:0] PKT_MOVE           = 2'b00;
   localparam logic [1:0] PKT_SETUP          = 2'b10;
   localparam logic [1:0] PKT_HEARTBEAT_TYPE = 2'b11;

   localparam logic [PKT_W-1:0] PKT_HEARTBEAT = {PKT_HEARTBEAT_TYPE, 14'h0000};

endpackage

// File: rtl/uart_tx_scheduler_arbiter.sv
// Fixed-priority arbiter: the lowest-index active request wins.
// Purely combinational; the one-hot grant is qualified by the caller.
module fixed_prio_arbiter #(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         any
);

   logic taken;

   always_comb begin
      grant = '0;
      taken = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !taken) begin
            grant[i] = 1'b1;
            taken    = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit channel between prioritised packet producers,
// tracks each frame to completion, enforces an inter-packet gap and inserts heartbeats.
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int N_REQ         = 3,
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 8,
   parameter int HB_PERIOD     = 50_000_000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ-1:0][PKT_W-1:0]   req_data,
   output logic [N_REQ-1:0]              req_ready,
   input  logic                          hb_enable,
   input  logic                          err_clear,
   input  logic                          uart_tx_busy,
   output logic                          uart_data_valid,
   output logic [PKT_W-1:0]              uart_data,
   output logic                          sent_pulse,
   output logic [$clog2(N_REQ+1)-1:0]    sent_src,
   output logic                          link_error,
   output logic                          sched_busy
);

   localparam int SRC_W = $clog2(N_REQ + 1);
   localparam int HB_W  = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
   localparam int TO_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_PERIOD - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [SRC_W-1:0] SRC_HB   = SRC_W'(N_REQ);

   tx_sched_state_t state;
   tx_sched_state_t state_nxt;

   logic [N_REQ-1:0] grant;
   logic             any_req;
   logic [SRC_W-1:0] grant_idx;
   logic [PKT_W-1:0] grant_pkt;

   logic [HB_W-1:0]  hb_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic in_idle;
   logic hb_expired;
   logic start_req;
   logic start_hb;
   logic start_timeout;
   logic frame_done;
   logic gap_done;

   fixed_prio_arbiter #(
      .N(N_REQ)
   ) u_arbiter (
      .req  (req_valid),
      .grant(grant),
      .any  (any_req)
   );

   always_comb begin
      grant_idx = '0;
      grant_pkt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = SRC_W'(i);
            grant_pkt = req_data[i];
         end
      end
   end

   assign in_idle       = (state == IDLE);
   assign hb_expired    = hb_enable && (hb_cnt == HB_LAST);
   assign start_req     = in_idle && any_req;
   assign start_hb      = in_idle && !any_req && hb_expired;
   assign start_timeout = (state == WAIT_START) && !uart_tx_busy && (to_cnt == TO_LAST);
   assign frame_done    = (state == WAIT_DONE) && !uart_tx_busy;
   assign gap_done      = (state == GAP) && (gap_cnt == GAP_ONE);

   // Grants exist only in IDLE, so requests arriving during GAP are held off.
   assign req_ready       = in_idle ? grant : '0;
   assign uart_data_valid = (state == LAUNCH);
   assign sched_busy      = !in_idle;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_req || start_hb) begin
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: state_nxt = WAIT_START;
         WAIT_START: begin
            if (uart_tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (start_timeout) begin
               state_nxt = GAP;
            end
         end
         WAIT_DONE: begin
            if (frame_done) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (gap_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Heartbeat idle timer: counts only while the link is idle and unrequested.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hb_cnt <= '0;
      end else if (!hb_enable || (state == LAUNCH)) begin
         hb_cnt <= '0;
      end else if (in_idle && !any_req && (hb_cnt != HB_LAST)) begin
         hb_cnt <= hb_cnt + HB_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state == LAUNCH) begin
         to_cnt <= '0;
      end else if ((state == WAIT_START) && !uart_tx_busy && (to_cnt != TO_LAST)) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // The gap is loaded on both normal completion and start timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_cnt <= '0;
      end else if (frame_done || start_timeout) begin
         gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
         gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uart_data <= '0;
         sent_src  <= '0;
      end else if (start_req) begin
         uart_data <= grant_pkt;
         sent_src  <= grant_idx;
      end else if (start_hb) begin
         uart_data <= PKT_HEARTBEAT;
         sent_src  <= SRC_HB;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sent_pulse <= 1'b0;
      end else begin
         sent_pulse <= frame_done;
      end
   end

   // A timeout in the same cycle as err_clear keeps the error set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         link_error <= 1'b0;
      end else if (start_timeout) begin
         link_error <= 1'b1;
      end else if (err_clear) begin
         link_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized traffic,
// every output compared each cycle against a behavioural model of the scheduling rules.
module tb_uart_tx_scheduler;

   localparam int N = 3;
   localparam int G = 16;
   localparam int T = 8;
   localparam int P = 40;

   localparam int PH_IDLE = 0;
   localparam int PH_LAUNCH = 1;
   localparam int PH_WAIT_START = 2;
   localparam int PH_WAIT_DONE = 3;
   localparam int PH_GAP = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [N-1:0]        req_valid = '0;
   logic [N-1:0][15:0]  req_data = '0;
   logic [N-1:0]        req_ready;
   logic                hb_enable = 1'b0;
   logic                err_clear = 1'b0;
   logic                uart_tx_busy = 1'b0;
   logic                uart_data_valid;
   logic [15:0]         uart_data;
   logic                sent_pulse;
   logic [1:0]          sent_src;
   logic                link_error;
   logic                sched_busy;

   uart_tx_scheduler #(
      .N_REQ(N),
      .GAP_CYCLES(G),
      .START_TIMEOUT(T),
      .HB_PERIOD(P)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .hb_enable(hb_enable),
      .err_clear(err_clear),
      .uart_tx_busy(uart_tx_busy),
      .uart_data_valid(uart_data_valid),
      .uart_data(uart_data),
      .sent_pulse(sent_pulse),
      .sent_src(sent_src),
      .link_error(link_error),
      .sched_busy(sched_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lowest_set(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Behavioural model: phase, elapsed WAIT_START cycles, absolute end of gap, idle-run count.
   int          m_phase = PH_IDLE;
   int          m_wait = 0;
   int          m_hb = 0;
   longint      m_cyc = 0;
   longint      m_gap_last = 0;
   logic [15:0] m_data = '0;
   int          m_src = 0;
   bit          m_pulse = 0;
   bit          m_err = 0;
   logic [N-1:0] seen_ready = '0;

   always @(negedge clk) begin
      logic [N-1:0] exp_ready;
      int g;
      int hb_n;
      bit timeout;
      bit pulse_n;
      seen_ready = req_ready;
      if (reset) begin
         check("rst_ready", req_ready, 0);
         check("rst_valid", uart_data_valid, 0);
         check("rst_data", uart_data, 0);
         check("rst_pulse", sent_pulse, 0);
         check("rst_src", sent_src, 0);
         check("rst_err", link_error, 0);
         check("rst_busy", sched_busy, 0);
         m_phase = PH_IDLE; m_wait = 0; m_hb = 0; m_data = '0;
         m_src = 0; m_pulse = 0; m_err = 0;
      end else begin
         g = lowest_set(req_valid);
         exp_ready = '0;
         if (m_phase == PH_IDLE && g >= 0) exp_ready[g] = 1'b1;
         check("cyc_ready", req_ready, exp_ready);
         check("cyc_valid", uart_data_valid, (m_phase == PH_LAUNCH));
         check("cyc_data", uart_data, m_data);
         check("cyc_pulse", sent_pulse, m_pulse);
         check("cyc_src", sent_src, m_src);
         check("cyc_err", link_error, m_err);
         check("cyc_busy", sched_busy, (m_phase != PH_IDLE));

         hb_n = m_hb;
         if (!hb_enable || m_phase == PH_LAUNCH) hb_n = 0;
         else if (m_phase == PH_IDLE && g < 0 && m_hb < P - 1) hb_n = m_hb + 1;
         timeout = 0;
         pulse_n = 0;
         case (m_phase)
            PH_IDLE: begin
               if (g >= 0) begin
                  m_data = req_data[g]; m_src = g; m_phase = PH_LAUNCH;
               end else if (hb_enable && m_hb == P - 1) begin
                  m_data = 16'hC000; m_src = N; m_phase = PH_LAUNCH;
               end
            end
            PH_LAUNCH: begin
               m_wait = 0; m_phase = PH_WAIT_START;
            end
            PH_WAIT_START: begin
               if (uart_tx_busy) m_phase = PH_WAIT_DONE;
               else if (m_wait == T - 1) begin
                  timeout = 1; m_phase = PH_GAP; m_gap_last = m_cyc + G;
               end else m_wait++;
            end
            PH_WAIT_DONE: begin
               if (!uart_tx_busy) begin
                  pulse_n = 1; m_phase = PH_GAP; m_gap_last = m_cyc + G;
               end
            end
            default: begin
               if (m_cyc == m_gap_last) m_phase = PH_IDLE;
            end
         endcase
         if (timeout) m_err = 1;
         else if (err_clear) m_err = 0;
         m_pulse = pulse_n;
         m_hb = hb_n;
      end
      m_cyc++;
   end

   // UART stand-in: after each launch strobe, busy rises after a delay for a frame length.
   bit strobe_q = 0;
   bit nostart = 0;
   bit rand_resp = 0;
   int frame_len = 3;
   int start_dly = 0;

   always @(negedge clk) strobe_q = uart_data_valid;

   initial begin
      int left = 0;
      int wait_left = 0;
      int cur_frame = 0;
      bit armed = 0;
      forever begin
         @(posedge clk);
         #1;
         if (strobe_q && !nostart) begin
            if (rand_resp) begin
               cur_frame = $urandom_range(1, 6);
               wait_left = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 10) : $urandom_range(0, 2);
            end else begin
               cur_frame = frame_len;
               wait_left = start_dly;
            end
            armed = 1;
         end
         if (armed) begin
            if (wait_left == 0) begin
               uart_tx_busy = 1'b1; left = cur_frame; armed = 0;
            end else wait_left--;
         end else if (uart_tx_busy) begin
            left--;
            if (left <= 0) uart_tx_busy = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!sched_busy) begin ok = 1; break; end
      end
      check(tag, ok, 1);
      step();
   endtask

   task automatic wait_grant(output logic [N-1:0] got);
      got = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready != 0) begin got = req_ready; break; end
      end
   endtask

   initial begin
      logic [N-1:0] got;
      int n;
      bit ok;
      bit bad;
      repeat (3) step();
      check("reset_ready", req_ready, 0);
      check("reset_data", uart_data, 16'h0000);
      check("reset_busy", sched_busy, 0);
      reset = 1'b0;
      repeat (2) step();

      // single request from requester 1
      req_data[1] = 16'h1234;
      req_valid = 3'b010;
      @(negedge clk);
      check("single_ready", req_ready, 3'b010);
      step();
      req_valid = '0;
      @(negedge clk);
      check("single_strobe", uart_data_valid, 1);
      check("single_data", uart_data, 16'h1234);
      ok = 0; n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n++;
         if (sent_pulse) begin ok = 1; break; end
      end
      check("single_pulse_seen", ok, 1);
      check("single_pulse_latency", n, 5);
      check("single_src", sent_src, 1);
      wait_idle("single_idle");

      // contention: requester 0 keeps winning until it drops
      frame_len = 2;
      req_data[0] = 16'h1111; req_data[1] = 16'h2222; req_data[2] = 16'h3333;
      req_valid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         wait_grant(got);
         check("contend_grant", got, (k < 3) ? 3'b001 : 3'b010);
         if (k == 2) begin step(); req_valid[0] = 1'b0; end
      end
      step();
      req_valid = '0;
      wait_idle("contend_idle");

      // start timeout
      nostart = 1;
      req_data[0] = 16'h0BAD;
      req_valid = 3'b001;
      @(negedge clk);
      step();
      req_valid = '0;
      @(negedge clk);
      check("to_strobe", uart_data_valid, 1);
      n = 0; bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (sent_pulse) bad = 1;
         if (link_error) break;
      end
      check("to_latency", n, T + 1);
      check("to_no_pulse", bad, 0);
      wait_idle("to_idle");
      check("to_err_sticky", link_error, 1);
      nostart = 0;
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      @(negedge clk);
      check("to_err_cleared", link_error, 0);

      // heartbeat after P idle cycles
      step();
      hb_enable = 1'b1;
      n = 0; ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (uart_data_valid) begin ok = 1; break; end
      end
      check("hb_seen", ok, 1);
      check("hb_latency", n, P + 1);
      check("hb_data", uart_data, 16'hC000);
      check("hb_src", sent_src, 3);

      // request on the heartbeat expiry cycle wins
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (m_phase == PH_IDLE && m_hb == P - 1) begin ok = 1; break; end
      end
      check("hb_expiry_reached", ok, 1);
      req_data[2] = 16'h2ABC;
      req_valid = 3'b100;
      @(negedge clk);
      check("hb_clash_ready", req_ready, 3'b100);
      step();
      req_valid = '0;
      @(negedge clk);
      check("hb_clash_data", uart_data, 16'h2ABC);
      check("hb_clash_src", sent_src, 2);
      wait_idle("hb_clash_idle");
      hb_enable = 1'b0;

      // reset while the frame is in flight
      frame_len = 12;
      req_data[0] = 16'h0F0F;
      req_valid = 3'b001;
      @(negedge clk);
      step();
      req_valid = '0;
      step();
      step();
      check("rstmid_busy_before", sched_busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_valid", uart_data_valid, 0);
      check("rstmid_busy", sched_busy, 0);
      check("rstmid_data", uart_data, 16'h0000);
      check("rstmid_src", sent_src, 0);
      step();
      reset = 1'b0;
      frame_len = 2;
      step();
      req_data[1] = 16'h5A5A;
      req_valid = 3'b010;
      @(negedge clk);
      check("rstmid_new_ready", req_ready, 3'b010);
      step();
      req_valid = '0;
      @(negedge clk);
      check("rstmid_new_strobe", uart_data_valid, 1);
      check("rstmid_new_data", uart_data, 16'h5A5A);
      wait_idle("rstmid_idle");

      // randomized traffic
      rand_resp = 1;
      for (int c = 0; c < 4000; c++) begin
         step();
         if ($urandom_range(0, 199) == 0) hb_enable = ~hb_enable;
         err_clear = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && seen_ready[i]) req_valid[i] = 1'b0;
            else if (!req_valid[i]) begin
               if ($urandom_range(0, 5) == 0) begin
                  req_data[i] = 16'($urandom);
                  req_valid[i] = 1'b1;
               end
            end else if ($urandom_range(0, 39) == 0) req_valid[i] = 1'b0;
         end
      end
      step();
      req_valid = '0;
      hb_enable = 1'b0;
      err_clear = 1'b0;
      rand_resp = 0;
      repeat (60) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
